iicm_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one iic master (the MP8864 write engine) between NUM_REQ requesters.
- Accepts one byte write request at a time, then latches the data and launches the master with a one-cycle start.
- Detects completion from the master's finish flag and returns a done pulse to the owner.
- A watchdog breaks NACK-retry lockups: on expiry it pulses err to the owner and holds the master in reset.

---
 rtl/iicm_arb.sv | 134 +++++++++++++
 tb/tb_iicm_arb.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/iicm_arb.sv
// Round-robin arbiter/sequencer sharing one iic write master among NUM_REQ requesters.
// One byte transaction at a time; a watchdog aborts hung frames and pulses the master's reset.
module iicm_arb #(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 60000,
  parameter int RST_CYC = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [8*NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   gnt,
  output logic [NUM_REQ-1:0]   done,
  output logic [NUM_REQ-1:0]   err,
  output logic                 busy,
  output logic [7:0]           iic_data,
  output logic                 iic_start,
  input  logic                 iic_finish,
  output logic                 iic_rstn
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int LW = $clog2(NUM_REQ);

  typedef logic [CW-1:0] cnt_t;
  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, DRAIN, RECOVER} state_t;

  localparam cnt_t          TO_LAST  = cnt_t'(TIMEOUT - 1);
  localparam cnt_t          RC_LAST  = cnt_t'(RST_CYC - 1);
  localparam logic [LW-1:0] LAST_RST = LW'(NUM_REQ - 1);

  state_t                    state, state_n;
  logic [NUM_REQ-1:0][7:0]   req_byte;
  logic [LW-1:0]             last, last_n, sel;
  logic                      sel_vld;
  logic [NUM_REQ-1:0]        gnt_n, done_n, err_n;
  logic [7:0]                data_n;
  cnt_t                      cnt, cnt_n;
  logic                      finish_d, rstn_n, rise;

  assign req_byte  = req_data;
  assign rise      = iic_finish & ~finish_d;
  assign busy      = (state != IDLE);
  assign iic_start = (state == LAUNCH);

  // Rotating priority: the requester just after the last owner is searched first.
  always_comb begin
    sel     = '0;
    sel_vld = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!sel_vld && req[(int'(last) + k) % NUM_REQ]) begin
        sel_vld = 1'b1;
        sel     = LW'((int'(last) + k) % NUM_REQ);
      end
    end
  end

  always_comb begin
    state_n = state;
    gnt_n   = gnt;
    done_n  = '0;
    err_n   = '0;
    data_n  = iic_data;
    last_n  = last;
    cnt_n   = cnt;
    rstn_n  = 1'b1;
    case (state)
      IDLE: begin
        // The master ignores start while finishing, so never grant under finish.
        if (sel_vld && !iic_finish) begin
          gnt_n   = NUM_REQ'(1) << sel;
          data_n  = req_byte[sel];
          last_n  = sel;
          state_n = LAUNCH;
        end
      end
      LAUNCH: begin
        cnt_n   = '0;
        state_n = WAIT;
      end
      WAIT: begin
        if (rise) begin
          done_n  = gnt;
          gnt_n   = '0;
          state_n = DRAIN;
        end else if (cnt == TO_LAST) begin
          err_n   = gnt;
          gnt_n   = '0;
          rstn_n  = 1'b0;
          cnt_n   = '0;
          state_n = RECOVER;
        end else if (cnt != '1) begin
          cnt_n = cnt + 1'b1;
        end
      end
      DRAIN: begin
        if (!iic_finish) state_n = IDLE;
      end
      RECOVER: begin
        // Same counter times the reset pulse; release on the exit edge.
        if (cnt == RC_LAST) begin
          state_n = IDLE;
        end else begin
          rstn_n = 1'b0;
          if (cnt != '1) cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= '0;
      done     <= '0;
      err      <= '0;
      iic_data <= 8'h00;
      iic_rstn <= 1'b0;
      last     <= LAST_RST;
      finish_d <= 1'b0;
      cnt      <= '0;
    end else begin
      state    <= state_n;
      gnt      <= gnt_n;
      done     <= done_n;
      err      <= err_n;
      iic_data <= data_n;
      iic_rstn <= rstn_n;
      last     <= last_n;
      finish_d <= iic_finish;
      cnt      <= cnt_n;
    end
  end
endmodule

// File: tb/tb_iicm_arb.sv
// Bench for iicm_arb: transaction-level reference model feeds an event scoreboard;
// a monitor pops and compares whenever grant/start/done/err appear.
module tb_iicm_arb;
  localparam int N  = 4;
  localparam int TO = 100;
  localparam int RC = 4;
  localparam int EV_GNT = 0, EV_START = 1, EV_DONE = 2, EV_ERR = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_data;
  logic [N-1:0]   gnt, done, err;
  logic           busy, iic_start, iic_finish, iic_rstn;
  logic [7:0]     iic_data;

  iicm_arb #(.NUM_REQ(N), .TIMEOUT(TO), .RST_CYC(RC)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt), .done(done),
    .err(err), .busy(busy), .iic_data(iic_data), .iic_start(iic_start),
    .iic_finish(iic_finish), .iic_rstn(iic_rstn)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0, cyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int at(input int q[$], input int i);
    if (i < q.size()) return q[i];
    return -1;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // ---------------- reference model (transaction timeline) ----------------
  typedef struct {int kind; int idx; int data; int cyc;} ev_t;
  ev_t evq[$];

  logic [N-1:0]   exp_gnt = '0;
  logic           exp_busy = 1'b0, exp_rstn = 1'b0;
  logic [7:0]     exp_data = 8'h00;
  int             m_last = N - 1;
  logic           pfin = 1'b0, s_rst, s_fin, s_rise;
  logic [N-1:0]   s_req;
  logic [8*N-1:0] s_data;

  function automatic int rr_pick(input logic [N-1:0] r, input int lst);
    for (int k = 1; k <= N; k++) if (r[(lst + k) % N]) return (lst + k) % N;
    return -1;
  endfunction

  task automatic tick();
    @(posedge clk);
    cyc++;
    s_rst = rst; s_req = req; s_data = req_data; s_fin = iic_finish;
    s_rise = s_fin & ~pfin;
    pfin = s_rst ? 1'b0 : s_fin;
    if (s_rst) begin
      exp_gnt = '0; exp_busy = 1'b0; exp_data = 8'h00; exp_rstn = 1'b0; m_last = N - 1;
    end else exp_rstn = 1'b1;
  endtask

  task automatic push(input int kind, input int idx, input int data);
    ev_t e;
    e.kind = kind; e.idx = idx; e.data = data; e.cyc = cyc;
    evq.push_back(e);
  endtask

  task automatic run_txn();
    int sel, k, j;
    sel = rr_pick(s_req, m_last);
    m_last = sel;
    exp_gnt = N'(1) << sel;
    exp_data = s_data[8*sel +: 8];
    exp_busy = 1'b1;
    push(EV_GNT, sel, int'(exp_data));
    push(EV_START, 0, 0);
    tick(); if (s_rst) return;
    k = 0;
    forever begin
      tick(); if (s_rst) return;
      if (s_rise) begin
        exp_gnt = '0; push(EV_DONE, sel, 0); break;
      end
      if (k == TO - 1) begin
        exp_gnt = '0; exp_rstn = 1'b0; push(EV_ERR, sel, 0);
        j = 0;
        forever begin
          tick(); if (s_rst) return;
          if (j == RC - 1) begin exp_busy = 1'b0; return; end
          exp_rstn = 1'b0;
          j++;
        end
      end
      k++;
    end
    forever begin
      tick(); if (s_rst) return;
      if (!s_fin) begin exp_busy = 1'b0; return; end
    end
  endtask

  initial forever begin
    tick();
    if (!s_rst && s_req != '0 && !s_fin) run_txn();
  end

  // ---------------- monitor / scoreboard ----------------
  int glog[$], dlog[$], elog[$];
  logic [N-1:0] prev_g = '0;

  task automatic got(input int kind, input int idx, input int data);
    ev_t e;
    n_vec++;
    if (evq.size() == 0) begin
      n_bad++;
      $display("FAIL unexpected_event: got kind=%0d idx=%0d data=0x%0h at cycle %0d, want none", kind, idx, data, cyc);
    end else begin
      e = evq.pop_front();
      if (e.kind != kind || e.idx != idx || e.data != data || e.cyc != cyc) begin
        n_bad++;
        $display("FAIL event: got kind=%0d idx=%0d data=0x%0h cyc=%0d, want kind=%0d idx=%0d data=0x%0h cyc=%0d",
                 kind, idx, data, cyc, e.kind, e.idx, e.data, e.cyc);
      end
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    while (evq.size() > 0 && evq[0].cyc < cyc) begin
      n_vec++; n_bad++;
      $display("FAIL missing_event: got nothing, want kind=%0d idx=%0d at cycle %0d", evq[0].kind, evq[0].idx, evq[0].cyc);
      void'(evq.pop_front());
    end
    if (gnt != '0 && prev_g == '0) begin
      got(EV_GNT, oh_idx(gnt), int'(iic_data));
      glog.push_back(oh_idx(gnt));
    end
    if (iic_start === 1'b1) got(EV_START, 0, 0);
    if (done != '0) begin got(EV_DONE, oh_idx(done), 0); dlog.push_back(oh_idx(done)); end
    if (err != '0)  begin got(EV_ERR, oh_idx(err), 0);  elog.push_back(oh_idx(err));  end
    prev_g = gnt;
    chk("gnt_level", 32'(gnt), 32'(exp_gnt));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("iic_rstn", 32'(iic_rstn), 32'(exp_rstn));
    chk("iic_data", 32'(iic_data), 32'(exp_data));
    chk("onehot_excl", 32'($onehot0(gnt) && $onehot0(done) && $onehot0(err) && ((done & err) == '0)), 32'd1);
    chk("start_vs_finish", 32'(iic_start & iic_finish), 32'd0);
  end

  // ---------------- stimulus: requesters + iic master model ----------------
  int fin_dly, fin_len, tmr = -1, fcnt = 0;
  logic [N-1:0] hold;

  task automatic step();
    @(negedge clk);
    if (iic_rstn !== 1'b1) begin
      if (iic_rstn === 1'b0) begin iic_finish = 1'b0; tmr = -1; fcnt = 0; end
    end else begin
      if (iic_finish) begin fcnt--; if (fcnt <= 0) iic_finish = 1'b0; end
      if (tmr > 0) begin
        tmr--;
        if (tmr == 0) begin iic_finish = 1'b1; fcnt = fin_len; tmr = -1; end
      end
      if (iic_start === 1'b1 && fin_dly > 0) tmr = fin_dly;
    end
    for (int i = 0; i < N; i++) if ((done[i] || err[i]) && !hold[i]) req[i] = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      if (req == '0 && busy === 1'b0 && iic_finish == 1'b0) break;
      step();
    end
    chk("wait_idle", 32'({req, busy, iic_finish}), 32'd0);
  endtask

  task automatic wait_gnt(input int i, input int budget);
    for (int n = 0; n < budget; n++) begin
      if (gnt[i] === 1'b1) break;
      step();
    end
    chk("wait_gnt", 32'(gnt[i]), 32'd1);
  endtask

  task automatic do_reset();
    hold = '0; rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
  endtask

  task automatic clear_logs();
    glog.delete(); dlog.delete(); elog.delete();
  endtask

  initial begin
    rst = 1'b1; req = '0; req_data = '0; iic_finish = 1'b0; hold = '0;
    fin_dly = -1; fin_len = 10;
    repeat (3) step();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rstn", 32'(iic_rstn), 32'd0);
    chk("rst_data", 32'(iic_data), 32'd0);
    chk("rst_start", 32'(iic_start), 32'd0);
    chk("rst_done_err", 32'({done, err}), 32'd0);
    rst = 1'b0;
    step();
    chk("rstn_rise", 32'(iic_rstn), 32'd1);

    // single request
    clear_logs(); fin_dly = 50; fin_len = 40;
    req_data[15:8] = 8'h5A; req = 4'b0010;
    wait_idle(400);
    chk("single_gnt", 32'(at(glog, 0)), 32'd1);
    chk("single_done", 32'(at(dlog, 0)), 32'd1);

    // all four after reset: order 0,1,2,3
    do_reset(); clear_logs(); fin_dly = 20; fin_len = 15;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'h10 + 8'(i);
    req = '1;
    wait_idle(800);
    for (int i = 0; i < N; i++) chk("rr_order", 32'(at(glog, i)), 32'(i));

    // fairness: 0 and 2 held, alternate
    clear_logs(); hold = 4'b0101; req = 4'b0101;
    for (int n = 0; n < 800 && glog.size() < 4; n++) step();
    hold = '0;
    wait_idle(400);
    for (int i = 0; i < 4; i++) begin
      chk("fair_gnt", 32'(at(glog, i)), 32'((i % 2) * 2));
      chk("fair_done", 32'(at(dlog, i)), 32'((i % 2) * 2));
    end

    // timeout, then a pending requester is served
    clear_logs(); fin_dly = -1; req = 4'b0010;
    wait_gnt(1, 50);
    fin_dly = 20; req[3] = 1'b1;
    wait_idle(600);
    chk("to_err_cnt", 32'(elog.size()), 32'd1);
    chk("to_err_owner", 32'(at(elog, 0)), 32'd1);
    chk("to_next_gnt", 32'(at(glog, 1)), 32'd3);
    chk("to_next_done", 32'(at(dlog, 0)), 32'd3);

    // reset mid-WAIT: pointer restarts, req0 beats req3
    clear_logs(); fin_dly = -1; req = 4'b1000;
    wait_gnt(3, 50);
    repeat (50) step();
    req[0] = 1'b1; rst = 1'b1;
    step();
    chk("midrst_gnt", 32'(gnt), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_start", 32'(iic_start), 32'd0);
    chk("midrst_rstn", 32'(iic_rstn), 32'd0);
    rst = 1'b0; fin_dly = 15;
    wait_idle(600);
    chk("midrst_no_err", 32'(elog.size()), 32'd0);
    chk("midrst_first", 32'(at(glog, 1)), 32'd0);
    chk("midrst_second", 32'(at(glog, 2)), 32'd3);

    // request dropped after grant still completes
    clear_logs(); fin_dly = 30; req_data[15:8] = 8'hC3; req = 4'b0010;
    wait_gnt(1, 50);
    req[1] = 1'b0;
    wait_idle(300);
    chk("drop_done", 32'(at(dlog, 0)), 32'd1);
    chk("drop_no_err", 32'(elog.size()), 32'd0);

    // finish edge around the timeout boundary
    for (int d = TO - 1; d <= TO + 1; d++) begin
      clear_logs(); fin_dly = d; fin_len = 5; req = 4'b0100;
      wait_idle(500);
      chk("bnd_done", 32'(dlog.size()), 32'(d <= TO));
      chk("bnd_err", 32'(elog.size()), 32'(d > TO));
    end

    // randomized traffic
    repeat (60) begin
      for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'($urandom);
      fin_len = $urandom_range(1, 40);
      case ($urandom_range(0, 5))
        0: fin_dly = -1;
        1: fin_dly = TO - 1;
        2: fin_dly = TO;
        3: fin_dly = TO + 1;
        default: fin_dly = $urandom_range(1, TO - 2);
      endcase
      req = N'($urandom_range(1, (1 << N) - 1));
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(1, 60)) step();
        do_reset();
      end
      wait_idle(2000);
    end

    repeat (10) step();
    chk("evq_empty", 32'(evq.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: got no finish, want finish before 90000 cycles");
    $fatal(1, "bench timeout");
  end
endmodule
